// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Imported by fetch_out_reg and instruction_fetch.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_fetch_if.sv
// Downstream IF/ID handshake bundle: fetch side is master, decode side is slave.
interface instruction_fetch_if;

  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;

  modport master (
    output OutValid,
    output OutInstr,
    output OutPC,
    output OutPCPlus4,
    input  OutReady
  );

  modport slave (
    input  OutValid,
    input  OutInstr,
    input  OutPC,
    input  OutPCPlus4,
    output OutReady
  );

endinterface

// File: rtl/instruction_fetch_out_reg.sv
// IF/ID holding register: load, hold, flush, and valid drop on acceptance.
// Flush clears only the valid bit; the payload is left unchanged.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_pcplus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  // Payload and valid register; flush outranks load, load outranks acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      instr   <= 32'h0000_0000;
      pc      <= 32'h0000_0000;
      pcplus4 <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= d_instr;
      pc      <= d_pc;
      pcplus4 <= d_pcplus4;
    end else if (ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, BOOT/RUN/HALT FSM, next-PC mux and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN halts on misaligned redirects and sets MisalignErr.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                       Clk,
  input  logic                       Reset,
  output logic [31:0]                PC,
  input  logic [31:0]                InstructionCode,
  input  logic                       RedirectValid,
  input  logic [31:0]                RedirectPC,
  output logic                       MisalignErr,
  instruction_fetch_if.master        out_if
);

  fetch_state_t state_r;
  fetch_state_t state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  redirect_pc_s;
  logic         redirect_s;
  logic         capture_s;
  logic         halt_hit_s;
  logic         misalign_req_s;
  logic         load_s;
  logic         flush_s;

  assign pc_plus4_s    = pc_r + PC_STEP;
  assign redirect_pc_s = RedirectPC & ~32'h0000_0003;
  assign redirect_s    = RedirectValid && (state_r != BOOT);
  assign capture_s     = (state_r == RUN) && (!out_if.OutValid || out_if.OutReady);
  assign halt_hit_s    = (InstructionCode == HALT_WORD);
  assign PC            = pc_r;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_r;

  assign misalign_req_s = redirect_s && (RedirectPC[1:0] != 2'b00);
  assign MisalignErr    = misalign_r;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      misalign_r <= 1'b0;
    end else if (misalign_req_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end
`else
  assign misalign_req_s = 1'b0;
  assign MisalignErr    = 1'b0;
`endif

  // State and PC registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Next-state logic; a redirect outranks capture and halt detection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: state_nxt_s = RUN;
      RUN: begin
        if (redirect_s) begin
          state_nxt_s = misalign_req_s ? HALT : RUN;
        end else if (capture_s && halt_hit_s) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        if (redirect_s) begin
          state_nxt_s = misalign_req_s ? HALT : RUN;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // Output decode: register controls and next-PC mux.
  always_comb begin
    load_s   = capture_s && !redirect_s;
    flush_s  = redirect_s;
    pc_nxt_s = pc_r;
    if (redirect_s) begin
      pc_nxt_s = redirect_pc_s;
    end else if (capture_s && !halt_hit_s) begin
      pc_nxt_s = pc_plus4_s;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  fetch_out_reg u_out_reg (
    .clk       (Clk),
    .rst_n     (Reset),
    .load      (load_s),
    .flush     (flush_s),
    .ready     (out_if.OutReady),
    .d_instr   (InstructionCode),
    .d_pc      (pc_r),
    .d_pcplus4 (pc_plus4_s),
    .valid     (out_if.OutValid),
    .instr     (out_if.OutInstr),
    .pc        (out_if.OutPC),
    .pcplus4   (out_if.OutPCPlus4)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch plus a PC-wrap instance.
// Expectations track FETCH_ALIGN_CHECK_EN when it is defined for the build.
module tb_instruction_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] eop;
    logic [31:0] epc;
    logic        emis;
  } vec_t;

  logic        clk;
  logic        Reset;
  logic [31:0] PC;
  logic [31:0] InstructionCode;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        MisalignErr;

  logic        Reset2;
  logic [31:0] PC2;
  logic [31:0] InstructionCode2;
  logic        RedirectValid2;
  logic [31:0] RedirectPC2;
  logic        MisalignErr2;

  int nvec;
  int nmis;
  vec_t vecs[$];

  instruction_fetch_if oif ();
  instruction_fetch_if oif2 ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0011;
      32'h0000_0004: mem_word = 32'h0000_0022;
      32'h0000_0008: mem_word = 32'h0000_0033;
      32'h0000_000C: mem_word = 32'hFFFF_FFFF;
      default:       mem_word = {8'hA0, a[23:0]};
    endcase
  endfunction

  assign InstructionCode  = mem_word(PC);
  assign InstructionCode2 = mem_word(PC2);

  instruction_fetch dut (
    .Clk             (clk),
    .Reset           (Reset),
    .PC              (PC),
    .InstructionCode (InstructionCode),
    .RedirectValid   (RedirectValid),
    .RedirectPC      (RedirectPC),
    .MisalignErr     (MisalignErr),
    .out_if          (oif)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk             (clk),
    .Reset           (Reset2),
    .PC              (PC2),
    .InstructionCode (InstructionCode2),
    .RedirectValid   (RedirectValid2),
    .RedirectPC      (RedirectPC2),
    .MisalignErr     (MisalignErr2),
    .out_if          (oif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s row %0d: got %h, want %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] ei, input logic [31:0] eop,
                     input logic [31:0] epc, input logic emis);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.eop = eop; v.epc = epc; v.emis = emis;
    vecs.push_back(v);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    Reset = 1'b0; RedirectValid = 1'b0; RedirectPC = 32'h0; oif.OutReady = 1'b1;
    Reset2 = 1'b0; RedirectValid2 = 1'b0; RedirectPC2 = 32'h0; oif2.OutReady = 1'b1;

    // Wrap instance: fetch at FFFF_FFFC then at 0.
    step();
    chk("wrap_rst_pc", -1, PC2, 32'hFFFF_FFFC);
    chk("wrap_rst_valid", -1, {31'd0, oif2.OutValid}, 32'd0);
    Reset2 = 1'b1;
    step();
    chk("wrap_boot_valid", -1, {31'd0, oif2.OutValid}, 32'd0);
    step();
    chk("wrap_f1_valid", -1, {31'd0, oif2.OutValid}, 32'd1);
    chk("wrap_f1_outpc", -1, oif2.OutPC, 32'hFFFF_FFFC);
    chk("wrap_f1_pc4", -1, oif2.OutPCPlus4, 32'h0000_0000);
    chk("wrap_f1_pc", -1, PC2, 32'h0000_0000);
    step();
    chk("wrap_f2_outpc", -1, oif2.OutPC, 32'h0000_0000);
    chk("wrap_f2_pc4", -1, oif2.OutPCPlus4, 32'h0000_0004);
    chk("wrap_f2_instr", -1, oif2.OutInstr, 32'h0000_0011);

    //  rst   rdy   rv    rpc            ev    instr          outpc          pc             mis
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0011, 32'h0,         32'h4,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0022, 32'h4,         32'h8,         1'b0);
    for (int i = 0; i < 3; i++)
      add(1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0022, 32'h4,         32'h8,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0033, 32'h8,         32'hC,         1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         32'h100,       1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0100, 32'h100,       32'h104,       1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'h0,         32'h4,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0022, 32'h4,         32'h8,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0033, 32'h8,         32'hC,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'hC,         32'hC,         1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'hC,         32'hC,         1'b0);
    for (int i = 0; i < 11; i++)
      add(1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,         32'h0,         32'hC,         1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0011, 32'h0,         32'h4,         1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    add(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0,         32'h0,         32'h100,       1'b1);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h100,       1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h100,       1'b1);
`else
    add(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0,         32'h0,         32'h100,       1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0100, 32'h100,       32'h104,       1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0100, 32'h100,       32'h104,       1'b0);
`endif
    add(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0011, 32'h0,         32'h4,         1'b0);

    foreach (vecs[i]) begin
      Reset         = vecs[i].rst;
      oif.OutReady  = vecs[i].rdy;
      RedirectValid = vecs[i].rv;
      RedirectPC    = vecs[i].rpc;
      step();
      chk("valid", i, {31'd0, oif.OutValid}, {31'd0, vecs[i].ev});
      chk("pc", i, PC, vecs[i].epc);
      chk("misalign", i, {31'd0, MisalignErr}, {31'd0, vecs[i].emis});
      if (vecs[i].ev || !vecs[i].rst) begin
        chk("instr", i, oif.OutInstr, vecs[i].ei);
        chk("outpc", i, oif.OutPC, vecs[i].eop);
        chk("outpc4", i, oif.OutPCPlus4, vecs[i].rst ? vecs[i].eop + 32'd4 : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-side counterpart of the instruction memory: generates the program counter driven into the memory's `PC` input, captures the returned `InstructionCode` (combinational, same-cycle read) into an IF/ID output register, and hands instructions downstream with a valid/ready handshake. It handles downstream stalls, branch/jump redirects with flush, and a halt instruction. It sits between the instruction memory and the decode stage of the processor datapath.

## Interface

- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- `Clk`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-low reset. It is shared with the instruction memory.
- `PC`  out  32  fetch address to instruction memory; registered.
- `InstructionCode`  in  32  memory read data for the current `PC`, valid in the same cycle.
- `RedirectValid`  in  1  branch or jump taken; single-cycle pulse or level.
- `RedirectPC`  in  32  redirect target.
- `OutValid`  out  1  `OutInstr`, `OutPC` and `OutPCPlus4` hold a fetched instruction.
- `OutReady`  in  1  downstream accepts when `OutValid & OutReady`.
- `OutInstr`  out  32  fetched instruction.
- `OutPC`  out  32  address of `OutInstr`.
- `OutPCPlus4`  out  32  `OutPC + 4`, mod 2^32.
- `MisalignErr`  out  1  sticky misaligned-redirect flag. Tied 0 unless the configuration macro is defined.

## Operation

- States:
  - BOOT: entered on reset.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- Reset (`Reset`=0 at an edge) sets:
  - `PC`=`RESET_PC`, state=BOOT.
  - `OutValid`=0, `OutInstr`=0, `OutPC`=0, `OutPCPlus4`=0, `MisalignErr`=0.
- BOOT: lasts one cycle after reset release, with no capture. This gives the memory, which shares `Reset`, one cycle to initialise. Next state is RUN.
- Capture condition (RUN only): `!OutValid | OutReady`. On capture, at the edge:
  - `OutInstr`←`InstructionCode`, `OutPC`←`PC`, `OutPCPlus4`←`PC+4`.
  - `OutValid`←1.
  - `PC`←`PC+4`.
- Stall: in RUN with `OutValid & !OutReady`, all output registers and `PC` hold.
- Halt:
  - A capture whose `InstructionCode`==`HALT_WORD` still presents that word on the output.
  - `PC` is not incremented, and the state moves to HALT.
  - In HALT there are no captures. `OutValid` clears once the held word is accepted.
- Redirect has highest priority over capture, stall and halt, in any state except BOOT:
  - `PC`←`RedirectPC` (alignment per Configuration).
  - `OutValid`←0, which flushes the held instruction even if `OutReady`=1 that cycle.
  - State→RUN.
  - An instruction that would have been captured in the same cycle is discarded.
- Redirect during BOOT is ignored.
- Arithmetic: all PC adds are 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Reset mid-operation overrides everything, including a simultaneous redirect and a pending output.

## Timing

- `PC` changes only at clock edges; the memory sees a stable address for a full cycle.
- Fetch latency:
  - A `PC` presented in RUN appears on `OutInstr` one edge later.
  - The first `OutValid`=1 is at the second rising edge after `Reset` deasserts.
- Throughput is one instruction per cycle while `OutReady`=1.
- Redirect penalty: `RedirectValid` at edge N gives `OutValid`=0 after N. The target instruction is valid after N+1.
- Downstream must not depend on `OutInstr` while `OutValid`=0.

## Configuration

- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `RedirectPC[1:0]`≠0 sets `MisalignErr`=1 (sticky until reset).
  - `PC` loads the masked address, state→HALT, `OutValid`←0.
- `FETCH_ALIGN_CHECK_EN` not defined:
  - `RedirectPC[1:0]` is silently forced to 00, state→RUN.
  - `MisalignErr` is constant 0.

## Structure

- Package `fetch_pkg` contains:
  - `fetch_state_t` enum {BOOT, RUN, HALT}.
  - `PC_STEP`=4.
  - Default `RESET_PC` and `HALT_WORD` constants.
- Sub-module `fetch_out_reg`: holding register for instr/PC/PC+4 with valid/ready, load, hold and flush. The top level keeps the FSM, PC register and next-PC mux.

## Test plan

- Reset release, `OutReady`=1, memory words 0x11,0x22,0x33 at 0x0,0x4,0x8 → `OutValid` first high at edge 2 with `OutInstr`=0x11 and `OutPC`=0; then 0x22 and 0x33 on consecutive cycles.
- `OutReady` low for 3 cycles while `OutInstr`=0x22 → `OutInstr`, `OutPC`=0x4 and `PC`=0x8 hold; fetch resumes with 0x33 after `OutReady` rises.
- `RedirectValid`=1 with `RedirectPC`=0x100 while `OutValid`=1 and `OutReady`=1 → next cycle `OutValid`=0 and `PC`=0x100; following cycle `OutPC`=0x100.
- Memory returns `HALT_WORD` at 0xC → it is presented once; after acceptance `OutValid`=0 and `PC` stays 0xC for 10 cycles; a redirect to 0x0 restarts fetch.
- `RESET_PC`=32'hFFFF_FFFC → second fetch has `OutPC`=0 and `OutPCPlus4`=4 (wrap).
- Redirect to 0x102: with `FETCH_ALIGN_CHECK_EN`, `MisalignErr`=1, `PC`=0x100 and state HALT; without it, fetch continues at 0x100 with `MisalignErr`=0. Assert `Reset`=0 mid-stall → all outputs return to reset values at the next edge.
